// File: rtl/bcd_pkg.sv
// bcd_pkg
//   Shared BCD definitions for the N-digit BCD counter and its digit step.
//   DIGIT_W         : bits per BCD digit
//   BCD_ZERO/NINE   : digit terminal values
//   MAX_DIGITS      : widest counter supported by the helper functions
//   is_all_nines()  : 1 when the low 'digits' digits of value are all 9
//   is_all_zeros()  : 1 when the low 'digits' digits of value are all 0
package bcd_pkg;
  localparam int DIGIT_W = 4;
  localparam logic [3:0] BCD_ZERO = 4'd0;
  localparam logic [3:0] BCD_NINE = 4'd9;
  localparam int MAX_DIGITS = 8;

  function automatic logic is_all_nines(input logic [4*MAX_DIGITS-1:0] value,
                                        input int digits);
    logic r;
    r = 1'b1;
    for (int i = 0; i < MAX_DIGITS; i++)
      if (i < digits && value[4*i +: 4] != BCD_NINE) r = 1'b0;
    return r;
  endfunction

  function automatic logic is_all_zeros(input logic [4*MAX_DIGITS-1:0] value,
                                        input int digits);
    logic r;
    r = 1'b1;
    for (int i = 0; i < MAX_DIGITS; i++)
      if (i < digits && value[4*i +: 4] != BCD_ZERO) r = 1'b0;
    return r;
  endfunction
endpackage

// File: rtl/bcd_digit_step.sv
// bcd_digit_step
//   Combinational single-digit BCD step, chained LSD to MSD.
//   digit      : current digit value (0..9)
//   up_dn      : 1 = increment, 0 = decrement
//   cin        : step request arriving from the lower digits
//   digit_next : digit after the step
//   cout       : step request passed on to the next digit (roll 9->0 / 0->9)
module bcd_digit_step
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  input  logic               up_dn,
  input  logic               cin,
  output logic [DIGIT_W-1:0] digit_next,
  output logic               cout
);

  always_comb begin
    digit_next = digit;
    cout       = 1'b0;
    if (cin) begin
      if (up_dn) begin
        if (digit >= BCD_NINE) begin
          digit_next = BCD_ZERO;
          cout       = 1'b1;
        end else begin
          digit_next = digit + 4'd1;
        end
      end else begin
        if (digit == BCD_ZERO) begin
          digit_next = BCD_NINE;
          cout       = 1'b1;
        end else begin
          digit_next = digit - 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/bcd_counter_ndigit.sv
// bcd_counter_ndigit
//   Registered N-digit BCD up/down counter with load, clear, wrap/saturate
//   mode and one-cycle carry / borrow / load_err pulses.
//   clk, reset      : rising-edge clock, synchronous active-high reset
//   en, up_dn       : count strobe and direction (1 = up)
//   clear, load     : synchronous clear / load (priority reset>clear>load>en)
//   load_value      : packed BCD preset, LSD in [3:0]; digits > 9 load as 9
//   bcd_out         : registered packed BCD value
//   carry, borrow   : step attempted from all-nines up / all-zeros down
//   load_err        : previous cycle's load had a digit forced to 9
module bcd_counter_ndigit
  import bcd_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int WRAP   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up_dn,
  input  logic                  clear,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  carry,
  output logic                  borrow,
  output logic                  load_err
);

  function automatic logic [3:0] sat_digit(input logic [3:0] d);
    return (d > BCD_NINE) ? BCD_NINE : d;
  endfunction

  logic [4*DIGITS-1:0] count_p1;
  logic [4*DIGITS-1:0] step_p0;
  logic [DIGITS:0]     chain_p0;
  logic [4*DIGITS-1:0] load_sat_p0;
  logic                load_bad_p0;

  // Stage p0: combinational next-value candidates
  assign chain_p0[0] = 1'b1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit_step u_step (
      .digit      (count_p1[4*g +: 4]),
      .up_dn      (up_dn),
      .cin        (chain_p0[g]),
      .digit_next (step_p0[4*g +: 4]),
      .cout       (chain_p0[g+1])
    );
  end

  always_comb begin
    load_sat_p0 = '0;
    load_bad_p0 = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      load_sat_p0[4*i +: 4] = sat_digit(load_value[4*i +: 4]);
      if (load_value[4*i +: 4] > BCD_NINE) load_bad_p0 = 1'b1;
    end
  end

  // Stage p1: registered value and pulses
  // chain_p0[DIGITS] is set only when every digit rolled, i.e. the counter
  // sat at its terminal value for the current direction.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_p1 <= '0;
      carry    <= 1'b0;
      borrow   <= 1'b0;
      load_err <= 1'b0;
    end else begin
      carry    <= 1'b0;
      borrow   <= 1'b0;
      load_err <= 1'b0;
      if (clear) begin
        count_p1 <= '0;
      end else if (load) begin
        count_p1 <= load_sat_p0;
        load_err <= load_bad_p0;
      end else if (en) begin
        if (!chain_p0[DIGITS] || (WRAP != 0)) count_p1 <= step_p0;
        carry  <= up_dn & chain_p0[DIGITS];
        borrow <= ~up_dn & chain_p0[DIGITS];
      end
    end
  end

  assign bcd_out = count_p1;

endmodule
